// File: rtl/redirect_arbiter.sv
// PC-redirect arbiter: picks CSR > late execute > early execute, holds the winner until fetch accepts.
// Optional REDIRECT_ARB_STATS_EN builds accepted-redirect and preempt counters.
module redirect_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_request_i,
  input  logic [31:0] csr_pc_i,
  input  logic [1:0]  csr_priv_i,
  input  logic        exu_request_i,
  input  logic [31:0] exu_pc_i,
  input  logic        exu_d_request_i,
  input  logic [31:0] exu_d_pc_i,
  input  logic [1:0]  cur_priv_i,
  input  logic        fetch_accept_i,
  output logic        fetch_branch_o,
  output logic [31:0] fetch_branch_pc_o,
  output logic [1:0]  fetch_branch_priv_o,
  output logic        squash_o,
  output logic [31:0] stat_redirects_o,
  output logic [31:0] stat_preempts_o
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  priv_q, priv_d;
  logic [1:0]  src_q, src_d;
  logic        squash_q, squash_d;

  logic        win_vld;
  logic [31:0] win_pc;
  logic [1:0]  win_priv;
  logic [1:0]  win_src;
  logic        xfer;
  logic        preempt;

  always_comb begin
    win_vld  = csr_request_i | exu_request_i | exu_d_request_i;
    win_pc   = exu_d_pc_i;
    win_priv = cur_priv_i;
    win_src  = 2'd2;
    if (csr_request_i) begin
      win_pc   = csr_pc_i;
      win_priv = csr_priv_i;
      win_src  = 2'd0;
    end else if (exu_request_i) begin
      win_pc   = exu_pc_i;
      win_src  = 2'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    priv_d   = priv_q;
    src_d    = src_q;
    squash_d = 1'b0;
    xfer     = 1'b0;
    preempt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = PENDING;
          pc_d     = win_pc;
          priv_d   = win_priv;
          src_d    = win_src;
          squash_d = 1'b1;
        end
      end
      PENDING: begin
        if (fetch_accept_i) begin
          xfer = 1'b1;
          if (win_vld) begin
            pc_d     = win_pc;
            priv_d   = win_priv;
            src_d    = win_src;
            squash_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        // Stalled: only a strictly older source, or a newer trap over a trap, may replace it.
        end else if (win_vld && ((win_src < src_q) || (win_src == 2'd0 && src_q == 2'd0))) begin
          pc_d     = win_pc;
          priv_d   = win_priv;
          src_d    = win_src;
          squash_d = 1'b1;
          preempt  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      priv_q   <= '0;
      src_q    <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      priv_q   <= priv_d;
      src_q    <= src_d;
      squash_q <= squash_d;
    end
  end

  assign fetch_branch_o      = (state_q == PENDING);
  assign fetch_branch_pc_o   = pc_q;
  assign fetch_branch_priv_o = priv_q;
  assign squash_o            = squash_q;

`ifdef REDIRECT_ARB_STATS_EN
  logic [31:0] stat_redirects_q, stat_preempts_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_redirects_q <= '0;
      stat_preempts_q  <= '0;
    end else begin
      if (xfer)    stat_redirects_q <= stat_redirects_q + 32'd1;
      if (preempt) stat_preempts_q  <= stat_preempts_q + 32'd1;
    end
  end

  assign stat_redirects_o = stat_redirects_q;
  assign stat_preempts_o  = stat_preempts_q;
`else
  logic unused_stats;
  assign unused_stats     = xfer ^ preempt;
  assign stat_redirects_o = '0;
  assign stat_preempts_o  = '0;
`endif

endmodule

// File: tb/tb_redirect_arbiter.sv
// Directed-vector bench for redirect_arbiter; stat expectations follow REDIRECT_ARB_STATS_EN.
module tb_redirect_arbiter;

`ifdef REDIRECT_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        csr_request_i, exu_request_i, exu_d_request_i, fetch_accept_i;
  logic [31:0] csr_pc_i, exu_pc_i, exu_d_pc_i;
  logic [1:0]  csr_priv_i, cur_priv_i;
  logic        fetch_branch_o, squash_o;
  logic [31:0] fetch_branch_pc_o, stat_redirects_o, stat_preempts_o;
  logic [1:0]  fetch_branch_priv_o;

  int nvec = 0;
  int nfail = 0;

  redirect_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .csr_request_i(csr_request_i), .csr_pc_i(csr_pc_i), .csr_priv_i(csr_priv_i),
    .exu_request_i(exu_request_i), .exu_pc_i(exu_pc_i),
    .exu_d_request_i(exu_d_request_i), .exu_d_pc_i(exu_d_pc_i),
    .cur_priv_i(cur_priv_i), .fetch_accept_i(fetch_accept_i),
    .fetch_branch_o(fetch_branch_o), .fetch_branch_pc_o(fetch_branch_pc_o),
    .fetch_branch_priv_o(fetch_branch_priv_o), .squash_o(squash_o),
    .stat_redirects_o(stat_redirects_o), .stat_preempts_o(stat_preempts_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    csr_request_i = 0; csr_pc_i = '0; csr_priv_i = '0;
    exu_request_i = 0; exu_pc_i = '0;
    exu_d_request_i = 0; exu_d_pc_i = '0;
    cur_priv_i = '0; fetch_accept_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1;
    step();
    rst_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (fetch_branch_o !== 1'b0) begin nfail++; $display("FAIL reset_valid got %0b want 0", fetch_branch_o); end
    nvec++; if (fetch_branch_pc_o !== 32'h0) begin nfail++; $display("FAIL reset_pc got %h want 0", fetch_branch_pc_o); end
    nvec++; if (fetch_branch_priv_o !== 2'd0) begin nfail++; $display("FAIL reset_priv got %0d want 0", fetch_branch_priv_o); end
    nvec++; if (squash_o !== 1'b0) begin nfail++; $display("FAIL reset_squash got %0b want 0", squash_o); end
    nvec++; if (stat_redirects_o !== 32'h0) begin nfail++; $display("FAIL reset_stat_redir got %0d want 0", stat_redirects_o); end
    nvec++; if (stat_preempts_o !== 32'h0) begin nfail++; $display("FAIL reset_stat_pre got %0d want 0", stat_preempts_o); end
    // accept while idle must not count or present anything
    fetch_accept_i = 1;
    step();
    fetch_accept_i = 0;
    nvec++; if (fetch_branch_o !== 1'b0 || stat_redirects_o !== 32'h0) begin nfail++; $display("FAIL idle_accept got v=%0b n=%0d want 0/0", fetch_branch_o, stat_redirects_o); end
  endtask

  task automatic test_basic();
    do_reset();
    exu_d_request_i = 1; exu_d_pc_i = 32'h0000_1000; cur_priv_i = 2'd1; fetch_accept_i = 1;
    step();
    exu_d_request_i = 0;
    nvec++; if (fetch_branch_o !== 1'b1) begin nfail++; $display("FAIL basic_valid got %0b want 1", fetch_branch_o); end
    nvec++; if (fetch_branch_pc_o !== 32'h0000_1000) begin nfail++; $display("FAIL basic_pc got %h want 00001000", fetch_branch_pc_o); end
    nvec++; if (fetch_branch_priv_o !== 2'd1) begin nfail++; $display("FAIL basic_priv got %0d want 1", fetch_branch_priv_o); end
    nvec++; if (squash_o !== 1'b1) begin nfail++; $display("FAIL basic_squash got %0b want 1", squash_o); end
    step();
    fetch_accept_i = 0;
    nvec++; if (fetch_branch_o !== 1'b0 || squash_o !== 1'b0) begin nfail++; $display("FAIL basic_retire got v=%0b s=%0b want 0/0", fetch_branch_o, squash_o); end
    nvec++; if (stat_redirects_o !== (STATS ? 32'd1 : 32'd0)) begin nfail++; $display("FAIL basic_stat got %0d want %0d", stat_redirects_o, STATS ? 1 : 0); end
  endtask

  task automatic test_priority();
    do_reset();
    csr_request_i = 1; csr_pc_i = 32'h8000_0000; csr_priv_i = 2'd3;
    exu_request_i = 1; exu_pc_i = 32'h2000;
    exu_d_request_i = 1; exu_d_pc_i = 32'h3000; cur_priv_i = 2'd1;
    step();
    clear_inputs();
    nvec++; if (fetch_branch_pc_o !== 32'h8000_0000 || fetch_branch_priv_o !== 2'd3) begin nfail++; $display("FAIL prio_csr got %h/%0d want 80000000/3", fetch_branch_pc_o, fetch_branch_priv_o); end
    do_reset();
    exu_request_i = 1; exu_pc_i = 32'h2000; exu_d_request_i = 1; exu_d_pc_i = 32'h3000; cur_priv_i = 2'd1;
    step();
    clear_inputs();
    nvec++; if (fetch_branch_pc_o !== 32'h2000 || fetch_branch_priv_o !== 2'd1) begin nfail++; $display("FAIL prio_exu got %h/%0d want 2000/1", fetch_branch_pc_o, fetch_branch_priv_o); end
  endtask

  task automatic test_preempt();
    do_reset();
    exu_d_request_i = 1; exu_d_pc_i = 32'h3000;
    step();
    exu_d_request_i = 0;
    step();
    nvec++; if (fetch_branch_pc_o !== 32'h3000 || squash_o !== 1'b0 || fetch_branch_o !== 1'b1) begin nfail++; $display("FAIL stall_hold got %h s=%0b want 3000 s=0", fetch_branch_pc_o, squash_o); end
    exu_request_i = 1; exu_pc_i = 32'h2000;
    step();
    exu_request_i = 0;
    nvec++; if (fetch_branch_pc_o !== 32'h2000 || squash_o !== 1'b1) begin nfail++; $display("FAIL preempt got %h s=%0b want 2000 s=1", fetch_branch_pc_o, squash_o); end
    nvec++; if (stat_preempts_o !== (STATS ? 32'd1 : 32'd0)) begin nfail++; $display("FAIL preempt_stat got %0d want %0d", stat_preempts_o, STATS ? 1 : 0); end
  endtask

  task automatic test_drop();
    do_reset();
    exu_request_i = 1; exu_pc_i = 32'h2000;
    step();
    exu_request_i = 0;
    exu_d_request_i = 1; exu_d_pc_i = 32'h3000;
    step();
    exu_d_request_i = 0;
    nvec++; if (fetch_branch_pc_o !== 32'h2000 || squash_o !== 1'b0) begin nfail++; $display("FAIL drop got %h s=%0b want 2000 s=0", fetch_branch_pc_o, squash_o); end
    nvec++; if (stat_preempts_o !== 32'd0) begin nfail++; $display("FAIL drop_stat got %0d want 0", stat_preempts_o); end
    // a second trap replaces a held trap; odd target passes unmodified
    do_reset();
    csr_request_i = 1; csr_pc_i = 32'h100; csr_priv_i = 2'd3;
    step();
    csr_pc_i = 32'h201; csr_priv_i = 2'd1;
    step();
    csr_request_i = 0;
    nvec++; if (fetch_branch_pc_o !== 32'h201 || fetch_branch_priv_o !== 2'd1 || squash_o !== 1'b1) begin nfail++; $display("FAIL csr_over_csr got %h/%0d s=%0b want 201/1 s=1", fetch_branch_pc_o, fetch_branch_priv_o, squash_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exu_request_i = 1; exu_pc_i = 32'h2000; cur_priv_i = 2'd0;
    step();
    exu_request_i = 0;
    step();
    fetch_accept_i = 1; csr_request_i = 1; csr_pc_i = 32'h100; csr_priv_i = 2'd2;
    step();
    fetch_accept_i = 0; csr_request_i = 0;
    nvec++; if (fetch_branch_o !== 1'b1 || fetch_branch_pc_o !== 32'h100 || fetch_branch_priv_o !== 2'd2) begin nfail++; $display("FAIL b2b got v=%0b %h/%0d want 1 100/2", fetch_branch_o, fetch_branch_pc_o, fetch_branch_priv_o); end
    nvec++; if (squash_o !== 1'b1) begin nfail++; $display("FAIL b2b_squash got %0b want 1", squash_o); end
    nvec++; if (stat_redirects_o !== (STATS ? 32'd1 : 32'd0) || stat_preempts_o !== 32'd0) begin nfail++; $display("FAIL b2b_stat got %0d/%0d want %0d/0", stat_redirects_o, stat_preempts_o, STATS ? 1 : 0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    exu_request_i = 1; exu_pc_i = 32'h2000; cur_priv_i = 2'd1;
    step();
    exu_request_i = 0;
    #2 rst_i = 1;
    #1;
    nvec++; if (fetch_branch_o !== 1'b0 || fetch_branch_pc_o !== 32'h0 || fetch_branch_priv_o !== 2'd0 || squash_o !== 1'b0) begin nfail++; $display("FAIL async_reset got v=%0b %h/%0d s=%0b want all 0", fetch_branch_o, fetch_branch_pc_o, fetch_branch_priv_o, squash_o); end
    step();
    rst_i = 0;
    step();
    step();
    nvec++; if (fetch_branch_o !== 1'b0 || squash_o !== 1'b0) begin nfail++; $display("FAIL post_reset got v=%0b s=%0b want 0/0", fetch_branch_o, squash_o); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic();
    test_priority();
    test_preempt();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/redirect_arbiter.md
# redirect_arbiter

Arbitrates PC-redirect requests from three sources and presents one registered redirect to the fetch unit. The three sources are CSR/exception, resolved execute branch, and early execute branch. Each redirect is held until fetch accepts it. The block sits between the execute stage, the CSR unit and fetch, and also generates the pipeline squash pulse.

## Interface
- No parameters.
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- csr_request_i  in  1  exception/trap/mret redirect request (priority 0, highest)
- csr_pc_i  in  32  CSR redirect target
- csr_priv_i  in  2  privilege level to enter with the CSR redirect
- exu_request_i  in  1  resolved (late) execute redirect, e.g. mispredict correction (priority 1)
- exu_pc_i  in  32  late redirect target
- exu_d_request_i  in  1  early execute taken-branch redirect (priority 2, lowest)
- exu_d_pc_i  in  32  early redirect target
- cur_priv_i  in  2  current privilege level; tagged onto execute-sourced redirects
- fetch_accept_i  in  1  fetch consumes the presented redirect this cycle
- fetch_branch_o  out  1  redirect valid
- fetch_branch_pc_o  out  32  redirect target
- fetch_branch_priv_o  out  2  redirect privilege
- squash_o  out  1  one-cycle pipeline flush pulse
- stat_redirects_o  out  32  count of accepted redirects (see Configuration)
- stat_preempts_o  out  32  count of overwritten pending redirects (see Configuration)

## Operation
- Held state:
  - pend_q: valid bit.
  - pc_q (32 bits) and priv_q (2 bits).
  - src_q: 2-bit source priority, 0 = CSR, 1 = late execute, 2 = early execute.
- Two states:
  - IDLE: pend_q = 0.
  - PENDING: pend_q = 1.
- Winner selection (combinational, each cycle):
  - The lowest-numbered active request wins.
  - The CSR winner carries csr_priv_i. Execute winners carry cur_priv_i.
- IDLE behaviour:
  - Any active request latches the winner (pc, priv, src) and moves to PENDING.
  - No request: stay in IDLE.
- PENDING, fetch_accept_i = 1: the held redirect retires.
  - If a request is active in the same cycle, its winner is latched and the state stays PENDING (back-to-back, no bubble).
  - Otherwise go to IDLE.
- PENDING, fetch_accept_i = 0:
  - A winner with priority strictly higher than src_q overwrites the held redirect (preempt).
  - A new CSR request also overwrites a held CSR redirect; the latest trap wins.
  - Any other request is dropped. The requester is younger and will be squashed.
- squash_o is registered. It is 1 in the cycle after any latch (new, back-to-back or preempt), otherwise 0.
- Outputs are driven straight from registers: fetch_branch_o = pend_q, fetch_branch_pc_o = pc_q, fetch_branch_priv_o = priv_q.
- No PC arithmetic is performed. Targets pass through unmodified, bit 0 included.

## Timing
- Reset values: all outputs are 0 and the state is IDLE. The stat counters are also 0.
- Reset mid-operation: a pending redirect is discarded with no accept and no squash. Fetch must tolerate loss of the redirect because it is reset too.
- Latency: a request in cycle N gives fetch_branch_o = 1 and squash_o = 1 in cycle N+1.
- Handshake: a transfer completes on a clock edge where fetch_branch_o and fetch_accept_i are both 1.
  - fetch_accept_i while fetch_branch_o = 0 is ignored.
- Stability: while pending and not preempted, fetch_branch_pc_o and fetch_branch_priv_o are stable until accepted.
- Preempt during a stall: the output changes in the following cycle. The old target is never accepted after that edge.
- Simultaneous accept and preempt-eligible request: accept takes effect first, then the request is latched as a fresh redirect.

## Configuration
- Macro: REDIRECT_ARB_STATS_EN.
- Defined:
  - stat_redirects_o increments on each completed transfer.
  - stat_preempts_o increments on each overwrite of a held, unaccepted redirect.
  - Both are 32 bits and wrap from 0xFFFFFFFF to 0.
- Undefined: no counter registers are built, and both ports are tied to 0.

## Test plan
- Reset, then exu_d_request_i = 1 with exu_d_pc_i = 0x00001000 for one cycle, fetch_accept_i = 1 → the next cycle shows fetch_branch_o = 1, pc 0x00001000, priv = cur_priv_i, squash_o = 1. One cycle later fetch_branch_o = 0.
- csr, exu and exu_d requests all active in one cycle (pcs 0x80000000, 0x2000, 0x3000), csr_priv_i = 3 → pc 0x80000000, priv 3.
- Early redirect 0x3000 pending with fetch_accept_i = 0, then exu_request_i with pc 0x2000 → output becomes 0x2000 and squash_o pulses again. With stats enabled, stat_preempts_o = 1.
- Late redirect 0x2000 pending and stalled, then exu_d_request_i with 0x3000 → dropped, output stays 0x2000 and squash_o stays 0.
- Pending 0x2000 with fetch_accept_i = 1 and csr_request_i with 0x100 in the same cycle → the next cycle shows 0x100 with no idle bubble. With stats enabled, stat_redirects_o = 1.
- Assert rst_i while a redirect is pending → all outputs read 0 immediately (asynchronous), and nothing is presented after reset is released.
